// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command controller: select encodings,
// FSM states, flag bit positions and the carry-update rule.
package alu_pkg;

    // ALU select encodings
    localparam logic [3:0] ADD  = 4'h0;
    localparam logic [3:0] ADC  = 4'h1;
    localparam logic [3:0] SUB  = 4'h2;
    localparam logic [3:0] SBC  = 4'h3;
    localparam logic [3:0] NEG  = 4'h4;
    localparam logic [3:0] INC  = 4'h5;
    localparam logic [3:0] DEC  = 4'h6;
    localparam logic [3:0] PASS = 4'h7;
    localparam logic [3:0] AND  = 4'h8;
    localparam logic [3:0] OR   = 4'h9;
    localparam logic [3:0] XOR  = 4'hA;
    localparam logic [3:0] NOT  = 4'hB;
    localparam logic [3:0] ASL  = 4'hC;
    localparam logic [3:0] ASR  = 4'hD;
    localparam logic [3:0] LSL  = 4'hE;
    localparam logic [3:0] LSR  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Flag vector layout {C,Z,N,V,P}
    localparam int FLAG_C = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_P = 0;

    // Only the arithmetic group (ADD..DEC) produces a meaningful carry-out
    function automatic logic sel_updates_c(input logic [3:0] sel);
        return (sel <= DEC);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two combinational read ports, one
// synchronous write port, synchronous clear on reset.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREGS  = 8,
    parameter int DATA_W = 16,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [RW-1:0]     raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [RW-1:0]     raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic              we_i,
    input  logic [RW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [NREGS-1:0][DATA_W-1:0] regs_q;

    // Write port; reset has priority so an abandoned command never lands
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command-driven initiator for the external combinational ALU. Latches
// operands at accept, runs one EXEC cycle, writes back result and flags,
// then holds the response until it is consumed.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int NREGS  = 8,
    parameter int DATA_W = 16,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_sel,
    input  logic [RW-1:0]     cmd_rd,
    input  logic [RW-1:0]     cmd_rs1,
    input  logic [RW-1:0]     cmd_rs2,
    input  logic              cmd_imm_en,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [3:0]        alu_sel,
    output logic              alu_carry_in,
    input  logic [DATA_W:0]   alu_out,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic              alu_overflow,
    input  logic              alu_parity,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [4:0]        rsp_flags
);

    state_e            state_q;
    logic [DATA_W-1:0] op1_q, op2_q;
    logic [3:0]        sel_q;
    logic [RW-1:0]     rd_q;
    logic [4:0]        flags_q, flags_d;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [4:0]        rsp_flags_q;
    logic [DATA_W-1:0] rdata1, rdata2;

    alu_regfile #(
        .NREGS (NREGS),
        .DATA_W(DATA_W)
    ) u_regfile (
        .clk_i   (clk),
        .rst_i   (rst),
        .raddr1_i(cmd_rs1),
        .rdata1_o(rdata1),
        .raddr2_i(cmd_rs2),
        .rdata2_o(rdata2),
        .we_i    (state_q == ST_EXEC),
        .waddr_i (rd_q),
        .wdata_i (alu_out[DATA_W-1:0])
    );

    // Flags produced by the command in EXEC; C survives non-arithmetic ops
    always_comb begin
        flags_d         = flags_q;
        flags_d[FLAG_Z] = alu_zero;
        flags_d[FLAG_N] = alu_neg;
        flags_d[FLAG_V] = alu_overflow;
        flags_d[FLAG_P] = alu_parity;
        if (sel_updates_c(sel_q)) begin
            flags_d[FLAG_C] = alu_out[DATA_W];
        end
    end

    // Command FSM with operand latches, flag register and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op1_q       <= '0;
            op2_q       <= '0;
            sel_q       <= '0;
            rd_q        <= '0;
            flags_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        sel_q   <= cmd_sel;
                        rd_q    <= cmd_rd;
                        op1_q   <= rdata1;
                        op2_q   <= cmd_imm_en ? cmd_imm : rdata2;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    flags_q     <= flags_d;
                    rsp_data_q  <= alu_out[DATA_W-1:0];
                    rsp_flags_q <= flags_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Operands stay at their last latched values outside EXEC
    assign alu_op1      = op1_q;
    assign alu_op2      = op2_q;
    assign alu_sel      = sel_q;
    assign alu_carry_in = flags_q[FLAG_C];
    assign cmd_ready    = (state_q == ST_IDLE) && !rst;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_flags    = rsp_flags_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a behavioural ALU answers the DUT, and a
// register/flag model predicts every response.
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_imm_en;
    logic [3:0]  cmd_sel;
    logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic [15:0] cmd_imm;
    logic [15:0] alu_op1, alu_op2;
    logic [3:0]  alu_sel;
    logic        alu_carry_in;
    logic [16:0] alu_out;
    logic        alu_zero, alu_neg, alu_overflow, alu_parity;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic [4:0]  rsp_flags;

    int checks = 0;
    int failures = 0;

    logic [15:0] mregs [8];
    logic [4:0]  mflags;
    logic [15:0] obs_data;
    logic [4:0]  obs_flags;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
        .alu_carry_in(alu_carry_in), .alu_out(alu_out),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_overflow(alu_overflow),
        .alu_parity(alu_parity),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags)
    );

    // Behavioural ALU: returns {result[16:0], Z, N, V, P}; P is even parity
    function automatic logic [20:0] alu_f(input logic [3:0] sel, input logic [15:0] a,
                                          input logic [15:0] b, input logic ci);
        logic [16:0] r;
        logic        v;
        v = 1'b0;
        case (sel)
            4'd0:  r = {1'b0, a} + {1'b0, b};
            4'd1:  r = {1'b0, a} + {1'b0, b} + {16'd0, ci};
            4'd2:  r = {1'b0, a} - {1'b0, b};
            4'd3:  r = {1'b0, a} - {1'b0, b} - {16'd0, ci};
            4'd4:  r = 17'd0 - {1'b0, a};
            4'd5:  r = {1'b0, a} + 17'd1;
            4'd6:  r = {1'b0, a} - 17'd1;
            4'd7:  r = {1'b0, b};
            4'd8:  r = {1'b0, a & b};
            4'd9:  r = {1'b0, a | b};
            4'd10: r = {1'b0, a ^ b};
            4'd11: r = {1'b0, ~a};
            4'd12: r = {a, 1'b0};
            4'd13: r = {a[0], a[15], a[15:1]};
            4'd14: r = {1'b0, a[14:0], 1'b0};
            default: r = {a[0], 1'b0, a[15:1]};
        endcase
        if (sel == 4'd0 || sel == 4'd1) v = (a[15] == b[15]) && (r[15] != a[15]);
        if (sel == 4'd2 || sel == 4'd3) v = (a[15] != b[15]) && (r[15] != a[15]);
        return {r, r[15:0] == 16'd0, r[15], v, ~^r[15:0]};
    endfunction

    always_comb begin
        logic [20:0] res;
        res = alu_f(alu_sel, alu_op1, alu_op2, alu_carry_in);
        {alu_out, alu_zero, alu_neg, alu_overflow, alu_parity} = res;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = 16'd0;
        mflags = 5'd0;
    endtask

    // Issue one command, check EXEC operands, latency, response and stall behaviour
    task automatic run_cmd(input logic [3:0] sel, input int rd, input int rs1, input int rs2,
                           input logic imm_en, input logic [15:0] imm, input int stall);
        logic [15:0] a, b;
        logic [20:0] res;
        logic [4:0]  exp_f;
        int          n;
        a   = mregs[rs1];
        b   = imm_en ? imm : mregs[rs2];
        res = alu_f(sel, a, b, mflags[4]);
        exp_f = {(sel <= 4'd6) ? res[20] : mflags[4], res[3:0]};
        @(negedge clk);
        cmd_valid = 1'b1; cmd_sel = sel; cmd_rd = 3'(rd); cmd_rs1 = 3'(rs1);
        cmd_rs2 = 3'(rs2); cmd_imm_en = imm_en; cmd_imm = imm;
        rsp_ready = (stall == 0);
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("accept_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("exec_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("exec_op1", 32'(alu_op1), 32'(a));
        chk("exec_op2", 32'(alu_op2), 32'(b));
        chk("exec_sel", 32'(alu_sel), 32'(sel));
        chk("exec_cin", 32'(alu_carry_in), 32'(mflags[4]));
        mregs[rd] = res[19:4];
        mflags    = exp_f;
        @(negedge clk);
        chk("resp_valid", 32'(rsp_valid), 32'd1);
        chk("resp_data", 32'(rsp_data), 32'(mregs[rd]));
        chk("resp_flags", 32'(rsp_flags), 32'(mflags));
        obs_data  = rsp_data;
        obs_flags = rsp_flags;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data", 32'(rsp_data), 32'(obs_data));
            chk("stall_flags", 32'(rsp_flags), 32'(obs_flags));
            chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            if (i == 1) begin
                cmd_valid = 1'b1; cmd_sel = PASS; cmd_rd = 3'd0;
                cmd_imm_en = 1'b1; cmd_imm = 16'hDEAD;
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_sel = '0; cmd_rd = '0; cmd_rs1 = '0;
        cmd_rs2 = '0; cmd_imm_en = 1'b0; cmd_imm = '0; rsp_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        // reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("rst_alu_ops", {alu_op1, alu_op2}, 32'd0);
        chk("rst_alu_sel_cin", {27'd0, alu_sel, alu_carry_in}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", 32'(cmd_ready), 32'd1);

        // PASS imm 3 into r1, then ADD r1 + imm 4
        run_cmd(PASS, 1, 0, 0, 1'b1, 16'h0003, 0);
        run_cmd(ADD, 4, 1, 0, 1'b1, 16'h0004, 0);
        chk("add_data", 32'(obs_data), 32'h0007);
        chk("add_flags", 32'(obs_flags), 32'h00);

        // 0xFFFF + 1 carries out, then ADC 0 + 0 consumes the carry
        run_cmd(PASS, 1, 0, 0, 1'b1, 16'hFFFF, 0);
        run_cmd(ADD, 2, 1, 0, 1'b1, 16'h0001, 0);
        chk("carry_data", 32'(obs_data), 32'h0000);
        chk("carry_cz", 32'(obs_flags[4:3]), 32'h3);
        run_cmd(ADC, 3, 0, 0, 1'b1, 16'h0000, 0);
        chk("adc_data", 32'(obs_data), 32'h0001);
        chk("adc_c", 32'(obs_flags[4]), 32'd0);

        // Logic op leaves C alone
        run_cmd(ADD, 2, 1, 0, 1'b1, 16'h0001, 0);
        run_cmd(PASS, 5, 0, 0, 1'b1, 16'h00F0, 0);
        run_cmd(AND, 6, 5, 0, 1'b1, 16'h0F0F, 0);
        chk("and_data", 32'(obs_data), 32'h0000);
        chk("and_cz", 32'(obs_flags[4:3]), 32'h3);

        // Response backpressure for 10 cycles with an ignored cmd_valid pulse
        run_cmd(SUB, 7, 1, 5, 1'b0, 16'h0000, 10);

        // rd == rs1 read-modify-write, then dependent read
        run_cmd(PASS, 2, 0, 0, 1'b1, 16'h0005, 0);
        run_cmd(INC, 2, 2, 0, 1'b0, 16'h0000, 0);
        chk("inc_data", 32'(obs_data), 32'h0006);
        run_cmd(PASS, 7, 0, 2, 1'b0, 16'h0000, 0);
        chk("dep_pass_data", 32'(obs_data), 32'h0006);

        // Reset during EXEC abandons the write of 0x1234 to r3
        @(negedge clk);
        cmd_valid = 1'b1; cmd_sel = PASS; cmd_rd = 3'd3; cmd_imm_en = 1'b1; cmd_imm = 16'h1234;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_exec_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_flags", 32'(rsp_flags), 32'd0);
        chk("mid_rst_cin", 32'(alu_carry_in), 32'd0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mid_rel_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rel_ready", 32'(cmd_ready), 32'd1);
        run_cmd(PASS, 0, 0, 3, 1'b0, 16'h0000, 0);
        chk("r3_cleared", 32'(obs_data), 32'h0000);

        // Randomized commands against the model
        for (int k = 0; k < 60; k++) begin
            run_cmd(4'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 16'($urandom),
                    int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
